// File: rtl/regfile_wr_decode_32x32.sv
// MIPS integer register file: 2^ADDR_W x DATA_W, two async read ports, one debug port,
// one synchronous write port fed by a one-hot decode of the destination register number.

module regfile_entry #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (we) data_d = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign q = data_q;
endmodule

module regfile_wr_decode_32x32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              L_S,
  input  logic [ADDR_W-1:0] Wt_addr,
  input  logic [DATA_W-1:0] Wt_data,
  input  logic [ADDR_W-1:0] R_addr_A,
  input  logic [ADDR_W-1:0] R_addr_B,
  output logic [DATA_W-1:0] rdata_A,
  output logic [DATA_W-1:0] rdata_B,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
);
  localparam int NREG = 1 << ADDR_W;

  logic              wr_act;
  logic [NREG-1:0]   wr_en;
  logic [DATA_W-1:0] ent [NREG];
  logic [15:0]       wr_count_q, wr_count_d;
  logic              fwd_a, fwd_b;

  // $0 is never a real write: it neither stores nor counts nor forwards.
  assign wr_act = L_S && (Wt_addr != '0);

  always_comb begin
    wr_en = '0;
    if (wr_act) wr_en[Wt_addr] = 1'b1;
  end

  assign ent[0] = '0;

  for (genvar i = 1; i < NREG; i++) begin : g_ent
    regfile_entry #(.DATA_W(DATA_W)) u_ent (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_en[i]),
      .wdata (Wt_data),
      .q     (ent[i])
    );
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_act) wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_count_q <= '0;
    else     wr_count_q <= wr_count_d;
  end

  assign fwd_a    = BYPASS && wr_act && (R_addr_A == Wt_addr);
  assign fwd_b    = BYPASS && wr_act && (R_addr_B == Wt_addr);
  assign rdata_A  = fwd_a ? Wt_data : ent[R_addr_A];
  assign rdata_B  = fwd_b ? Wt_data : ent[R_addr_B];
  assign dbg_data = ent[dbg_addr];
  assign wr_count = wr_count_q;
endmodule

// File: tb/tb_regfile_wr_decode_32x32.sv
// Bench for regfile_wr_decode_32x32: a BYPASS=1 and a BYPASS=0 instance share all inputs.
module tb_regfile_wr_decode_32x32;
  logic        clk = 1'b0;
  logic        rst;
  logic        L_S;
  logic [4:0]  Wt_addr, R_addr_A, R_addr_B, dbg_addr;
  logic [31:0] Wt_data;
  logic [31:0] rdata_A, rdata_B, dbg_data;
  logic [31:0] rdata_A0, rdata_B0, dbg_data0;
  logic [15:0] wr_count, wr_count0;

  always #5 clk = ~clk;

  regfile_wr_decode_32x32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut_byp (
    .clk(clk), .rst(rst), .L_S(L_S), .Wt_addr(Wt_addr), .Wt_data(Wt_data),
    .R_addr_A(R_addr_A), .R_addr_B(R_addr_B), .rdata_A(rdata_A), .rdata_B(rdata_B),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_count(wr_count)
  );

  regfile_wr_decode_32x32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nob (
    .clk(clk), .rst(rst), .L_S(L_S), .Wt_addr(Wt_addr), .Wt_data(Wt_data),
    .R_addr_A(R_addr_A), .R_addr_B(R_addr_B), .rdata_A(rdata_A0), .rdata_B(rdata_B0),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data0), .wr_count(wr_count0)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  typedef struct {
    logic        ls;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra, rb, da;
    logic [31:0] exp_a, exp_b, exp_d;     // BYPASS=1, before the edge
    logic [31:0] exp_a0, exp_b0;          // BYPASS=0, before the edge
    logic [15:0] exp_cnt;                 // after the edge
  } vec_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic push(input string name, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] act);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty: got %h with no expected value queued", act);
    end else begin
      e = sb.pop_front();
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sweep_val(input int i);
    return (i == 0) ? 32'h0 : ((32'(i) << 8) | 32'(i));
  endfunction

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    // ls wa  wd            ra rb da  exp_a         exp_b         exp_d         exp_a0        exp_b0        cnt
    vecs[0] = '{1'b1, 5'd8, 32'h1234_5678, 5'd8, 5'd8, 5'd8, 32'h1234_5678, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 16'd1};
    vecs[1] = '{1'b0, 5'd0, 32'h0, 5'd8, 5'd8, 5'd8, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 16'd1};
    vecs[2] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd8, 5'd0, 32'h0, 32'h1234_5678, 32'h0, 32'h0, 32'h1234_5678, 16'd1};
    vecs[3] = '{1'b1, 5'd3, 32'h11, 5'd3, 5'd0, 5'd3, 32'h11, 32'h0, 32'h0, 32'h0, 32'h0, 16'd2};
    vecs[4] = '{1'b1, 5'd3, 32'h22, 5'd3, 5'd3, 5'd3, 32'h22, 32'h22, 32'h11, 32'h11, 32'h11, 16'd3};
    vecs[5] = '{1'b0, 5'd3, 32'h33, 5'd3, 5'd3, 5'd3, 32'h22, 32'h22, 32'h22, 32'h22, 32'h22, 16'd3};
    vecs[6] = '{1'b1, 5'd9, 32'hCAFE_F00D, 5'd3, 5'd9, 5'd8, 32'h22, 32'hCAFE_F00D, 32'h1234_5678, 32'h22, 32'h0, 16'd4};

    rst = 1'b1; L_S = 1'b0; Wt_addr = '0; Wt_data = '0;
    R_addr_A = 5'd5; R_addr_B = 5'd31; dbg_addr = 5'd17;
    #12;
    push("reset_rdata_A", 32'h0);  push("reset_rdata_B", 32'h0);
    push("reset_dbg", 32'h0);      push("reset_wr_count", 32'h0);
    pop_chk(rdata_A); pop_chk(rdata_B); pop_chk(dbg_data); pop_chk({16'h0, wr_count});
    rst = 1'b0;

    // write $5 then assert reset asynchronously between edges
    tick();
    L_S = 1'b1; Wt_addr = 5'd5; Wt_data = 32'hDEAD_BEEF;
    tick();
    L_S = 1'b0;
    push("pre_rst_rdata_A5", 32'hDEAD_BEEF); push("pre_rst_count", 32'd1);
    #1 pop_chk(rdata_A); pop_chk({16'h0, wr_count});
    rst = 1'b1;
    push("async_rst_rdata_A5", 32'h0); push("async_rst_rdata_A5_nob", 32'h0);
    push("async_rst_count", 32'h0);
    #1 pop_chk(rdata_A); pop_chk(rdata_A0); pop_chk({16'h0, wr_count});
    rst = 1'b0;
    tick();

    for (int v = 0; v < 7; v++) begin
      L_S = vecs[v].ls; Wt_addr = vecs[v].wa; Wt_data = vecs[v].wd;
      R_addr_A = vecs[v].ra; R_addr_B = vecs[v].rb; dbg_addr = vecs[v].da;
      push($sformatf("vec%0d_rdata_A", v), vecs[v].exp_a);
      push($sformatf("vec%0d_rdata_B", v), vecs[v].exp_b);
      push($sformatf("vec%0d_dbg", v), vecs[v].exp_d);
      push($sformatf("vec%0d_rdata_A_nob", v), vecs[v].exp_a0);
      push($sformatf("vec%0d_rdata_B_nob", v), vecs[v].exp_b0);
      push($sformatf("vec%0d_dbg_nob", v), vecs[v].exp_d);
      #1;
      pop_chk(rdata_A); pop_chk(rdata_B); pop_chk(dbg_data);
      pop_chk(rdata_A0); pop_chk(rdata_B0); pop_chk(dbg_data0);
      tick();
      push($sformatf("vec%0d_count", v), {16'h0, vecs[v].exp_cnt});
      pop_chk({16'h0, wr_count});
    end
    L_S = 1'b0;

    // full sweep from a clean reset
    pulse_reset();
    tick();
    for (int i = 1; i < 32; i++) begin
      L_S = 1'b1; Wt_addr = 5'(i); Wt_data = sweep_val(i);
      tick();
    end
    L_S = 1'b0;
    for (int i = 0; i < 32; i++) begin
      R_addr_A = 5'(i); R_addr_B = 5'(31 - i); dbg_addr = 5'(i);
      push($sformatf("sweep_A_%0d", i), sweep_val(i));
      push($sformatf("sweep_B_%0d", 31 - i), sweep_val(31 - i));
      push($sformatf("sweep_dbg_%0d", i), sweep_val(i));
      #1 pop_chk(rdata_A); pop_chk(rdata_B); pop_chk(dbg_data);
    end
    push("sweep_count", 32'd31);
    pop_chk({16'h0, wr_count});

    // 65536 writes to $1 wrap the counter back to where it started
    L_S = 1'b1; Wt_addr = 5'd1; Wt_data = sweep_val(1);
    for (int n = 0; n < 65536; n++) tick();
    L_S = 1'b0; R_addr_A = 5'd1;
    push("wrap_count", 32'd31); push("wrap_reg1", sweep_val(1));
    #1 pop_chk({16'h0, wr_count}); pop_chk(rdata_A);

    // writes held across reset edges are discarded
    rst = 1'b1;
    L_S = 1'b1; Wt_addr = 5'd7; Wt_data = 32'hA5A5_A5A5;
    R_addr_A = 5'd7; R_addr_B = 5'd7; dbg_addr = 5'd7;
    for (int n = 0; n < 3; n++) tick();
    push("inrst_dbg7", 32'h0); push("inrst_A7_nob", 32'h0); push("inrst_count", 32'h0);
    pop_chk(dbg_data); pop_chk(rdata_A0); pop_chk({16'h0, wr_count});
    L_S = 1'b0;
    #1 rst = 1'b0;
    push("postrst_A7", 32'h0); push("postrst_B7_nob", 32'h0);
    #1 pop_chk(rdata_A); pop_chk(rdata_B0);
    L_S = 1'b1;
    tick();
    L_S = 1'b0;
    push("first_wr_A7", 32'hA5A5_A5A5); push("first_wr_dbg7_nob", 32'hA5A5_A5A5);
    push("first_wr_count", 32'd1);
    #1 pop_chk(rdata_A); pop_chk(dbg_data0); pop_chk({16'h0, wr_count});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/regfile_wr_decode_32x32.md
Name: regfile_wr_decode_32x32

Overview:
- MIPS integer register file: 32 entries × 32 bits, two asynchronous read ports, one synchronous write port, one debug read port.
- Consumes the 5-bit write-register number produced by the destination-select mux (rd / rt / $31) and decodes it into one of 32 write enables.
- Sits between the ALU/memory writeback path and the ID-stage operand fetch.
- The debug port feeds the on-board display / VGA register viewer.

Parameters:
- DATA_W, 32, width of each register and of all data ports.
- ADDR_W, 5, register-number width; the block has 2^ADDR_W entries.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the A/B read ports; 0 = the read ports return the old register value until the clock edge.

Ports:
- clk  in  1  system clock; all register updates occur on the rising edge.
- rst  in  1  asynchronous, active-high reset; clears every register.
- L_S  in  1  write enable; sampled on the rising clk edge.
- Wt_addr  in  ADDR_W  destination register number, driven by the destination-select mux.
- Wt_data  in  DATA_W  writeback data.
- R_addr_A  in  ADDR_W  read port A register number (rs).
- R_addr_B  in  ADDR_W  read port B register number (rt).
- rdata_A  out  DATA_W  port A read data, combinational.
- rdata_B  out  DATA_W  port B read data, combinational.
- dbg_addr  in  ADDR_W  debug read register number.
- dbg_data  out  DATA_W  debug read data, combinational, never bypassed.
- wr_count  out  16  count of committed writes (writes to $0 excluded), for on-board debug display.

Behaviour:
- Storage: entries 1..31 are flops. Entry 0 is not stored; every read of address 0 returns 0 on all ports, regardless of BYPASS.
- Write decode:
  - One-hot decode of Wt_addr, gated by L_S.
  - On rising clk with L_S=1 and Wt_addr≠0: entry[Wt_addr] <= Wt_data, and wr_count increments by 1.
  - L_S=1 with Wt_addr=0: no state change, wr_count unchanged.
  - L_S=0: no state change.
- wr_count wraps from 16'hFFFF to 16'h0000 with no saturation or flag.
- Read, BYPASS=1:
  - If L_S=1, Wt_addr≠0 and R_addr_X==Wt_addr, then rdata_X = Wt_data (same-cycle forwarding).
  - Otherwise rdata_X = entry[R_addr_X].
  - Forwarding is evaluated independently for ports A and B; both may forward simultaneously when both addresses match.
- Read, BYPASS=0: rdata_X = entry[R_addr_X]. The new value is visible after the write edge.
- dbg_data = entry[dbg_addr] (0 for address 0). It ignores pending writes under both BYPASS settings.
- Latency:
  - Write: 1 clock edge.
  - Reads: zero-cycle combinational from address, or from Wt_data when forwarding.
- Reset:
  - When rst asserts, all entries and wr_count clear to 0 immediately, without waiting for a clock edge. rdata_A, rdata_B and dbg_data then read 0 for every address; under BYPASS=1 this holds only while no write is forwarding.
  - While rst=1, writes are blocked even if L_S=1 at a clock edge.
  - A write whose edge coincides with rst asserted is discarded.
  - The first write after reset takes effect at the first rising edge after rst deasserts.
- Reset mid-burst: any write sequence in progress is lost. After reset there is no partial state; every entry is 0.
- No X propagation: with all inputs known, all outputs are known, including immediately after reset.

Test Plan:
- Reset clear: write 32'hDEADBEEF to $5, then assert rst asynchronously between clock edges -> rdata_A (R_addr_A=5) reads 0 before the next edge; wr_count=0.
- Basic write/read: L_S=1, Wt_addr=8, Wt_data=32'h1234_5678, one edge; then R_addr_A=8, R_addr_B=8, dbg_addr=8 -> all three ports read 32'h1234_5678; wr_count=1.
- $0 immunity: L_S=1, Wt_addr=0, Wt_data=32'hFFFF_FFFF, one edge -> rdata_A (addr 0)=0, wr_count unchanged; with BYPASS=1 and the write still pending, rdata_A (addr 0)=0.
- Bypass:
  - Setup: $3 holds 32'h0000_0011. Drive L_S=1, Wt_addr=3, Wt_data=32'h0000_0022, R_addr_A=3, R_addr_B=3, dbg_addr=3, before the edge.
  - BYPASS=1 -> rdata_A=rdata_B=32'h22, dbg_data=32'h11.
  - BYPASS=0 -> all three read 32'h11 before the edge and 32'h22 after it.
- Full sweep plus counter wrap:
  - Write value (i<<8)|i to each register i=1..31, then read all on both ports -> each matches; rdata for i=0 reads 0; wr_count=31.
  - Force 65536 writes to $1 -> wr_count returns to 31 (wrap).
- Write during reset: hold rst=1 with L_S=1, Wt_addr=7, Wt_data=32'hA5A5_A5A5 across 3 edges, then deassert -> $7 reads 0.
  - Then perform one write -> $7 = 32'hA5A5_A5A5 after the first post-reset edge.
